// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: synchronises the PS/2 lines, deframes 11-bit frames and queues bytes for the CPU.
// Optional build macro PS2_PARITY_CHECK_EN enables odd-parity checking (status[2]); otherwise parity is ignored.
module ps2_key_rx #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       rd_en,
    input  logic       clr,
    output logic [7:0] rd_data,
    output logic [7:0] status,
    output logic       key_int
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // Index 0 carries ps2_clk, index 1 carries ps2_data; both idle high.
    logic [1:0]    r_meta;
    logic [1:0]    r_sync;
    logic          r_clk_prev;

    state_t        r_state;
    state_t        w_state_next;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic          r_par_ok;
    logic [TW-1:0] r_timeout;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_par_err;
    logic          r_frm_err;
    logic          r_ovf;
    logic          r_key_int;

    logic          w_fall;
    logic          w_bit;
    logic          w_par_good;
    logic          w_shift_en;
    logic          w_par_load;
    logic          w_push_req;
    logic          w_frm_set;
    logic          w_par_set;
    logic          w_pop;
    logic          w_full;
    logic          w_push;
    logic          w_drop;
    logic [4:0]    w_cnt_ext;
    logic [2:0]    w_cnt_sat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta     <= 2'b11;
            r_sync     <= 2'b11;
            r_clk_prev <= 1'b1;
        end else begin
            r_meta     <= {ps2_data, ps2_clk};
            r_sync     <= r_meta;
            r_clk_prev <= r_sync[0];
        end
    end

    assign w_fall = r_clk_prev & ~r_sync[0];
    assign w_bit  = r_sync[1];

`ifdef PS2_PARITY_CHECK_EN
    assign w_par_good = ^{r_shift, w_bit};
`else
    assign w_par_good = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A stalled frame (keyboard unplugged mid-byte) is dropped silently so the next start bit is seen.
    always_comb begin
        w_state_next = r_state;
        w_shift_en   = 1'b0;
        w_par_load   = 1'b0;
        w_push_req   = 1'b0;
        w_frm_set    = 1'b0;
        w_par_set    = 1'b0;
        if (r_state != S_IDLE && !w_fall && r_timeout == TO_LAST) begin
            w_state_next = S_IDLE;
        end else if (w_fall) begin
            case (r_state)
                S_IDLE: begin
                    if (!w_bit) begin
                        w_state_next = S_DATA;
                    end
                end
                S_DATA: begin
                    w_shift_en = 1'b1;
                    if (r_bit_cnt == 3'd7) begin
                        w_state_next = S_PARITY;
                    end
                end
                S_PARITY: begin
                    w_par_load   = 1'b1;
                    w_state_next = S_STOP;
                end
                S_STOP: begin
                    w_state_next = S_IDLE;
                    if (!w_bit) begin
                        w_frm_set = 1'b1;
                    end else if (!r_par_ok) begin
                        w_par_set = 1'b1;
                    end else begin
                        w_push_req = 1'b1;
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'h00;
            r_par_ok  <= 1'b0;
            r_timeout <= '0;
        end else begin
            if (r_state == S_IDLE && w_state_next == S_DATA) begin
                r_bit_cnt <= 3'd0;
            end else if (w_shift_en) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            if (w_shift_en) begin
                r_shift <= {w_bit, r_shift[7:1]};
            end
            if (w_par_load) begin
                r_par_ok <= w_par_good;
            end
            if (w_fall || w_state_next == S_IDLE) begin
                r_timeout <= '0;
            end else begin
                r_timeout <= r_timeout + TW'(1);
            end
        end
    end

    // When full, a push is still accepted if the head is popped in the same cycle.
    assign w_pop  = rd_en && (r_count != '0);
    assign w_full = (r_count == FULL_CNT);
    assign w_push = w_push_req && (!w_full || w_pop);
    assign w_drop = w_push_req && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_shift;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_key_int <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            r_key_int <= w_push;
        end
    end

    // Sticky flags: a new event wins over a clear arriving in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_par_err <= 1'b0;
            r_frm_err <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            if (w_par_set) begin
                r_par_err <= 1'b1;
            end else if (clr) begin
                r_par_err <= 1'b0;
            end
            if (w_frm_set) begin
                r_frm_err <= 1'b1;
            end else if (clr) begin
                r_frm_err <= 1'b0;
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign w_cnt_ext = 5'(r_count);
    assign w_cnt_sat = (w_cnt_ext > 5'd7) ? 3'd7 : w_cnt_ext[2:0];

    assign rd_data = (r_count != '0) ? r_mem[r_rd_ptr] : 8'h00;
    assign status  = {w_cnt_sat, r_ovf, r_frm_err, r_par_err, w_full, (r_count != '0)};
    assign key_int = r_key_int;

endmodule
